// File: rtl/crithitz_pkg.sv
// Shared types and defaults for the crit-hit overlay compositor.
// The display sequencer states and the default transparent key colour live here.
package crithitz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLINK = 2'd2
    } ovl_state_t;

    localparam logic [11:0] KEY_COLOR_DEFAULT = 12'h000;

    // Frame counter width: enough bits to reach the longer of the two phases.
    function automatic int frame_cnt_width(input int show_frames, input int blink_frames);
        int longest;
        longest = (show_frames > blink_frames) ? show_frames : blink_frames;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/crithitz_overlay_pipe_delay.sv
// Fixed-latency shift register with synchronous clear, used to align the
// undelayed blank strobe with the pixel colour inputs.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_reg [DEPTH];

            always_ff @(posedge clk) begin
                if (srst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/crithitz_overlay.sv
// Crit-hit sprite compositor: shows the sprite for SHOW_FRAMES, blinks it for
// BLINK_FRAMES, then goes idle; all state changes happen on the frame boundary.
module crithitz_overlay
    import crithitz_pkg::*;
#(
    parameter int          SHOW_FRAMES  = 60,
    parameter int          BLINK_FRAMES = 32,
    parameter int          BLINK_SHIFT  = 2,
    parameter logic [11:0] KEY_COLOR    = KEY_COLOR_DEFAULT,
    parameter int          PIPE_LAT     = 2
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       hit_trigger,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    input  logic [3:0] ovl_red,
    input  logic [3:0] ovl_green,
    input  logic [3:0] ovl_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       overlay_active
);

    localparam int               CNT_W      = frame_cnt_width(SHOW_FRAMES, BLINK_FRAMES);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    ovl_state_t       state_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic [CNT_W-1:0] frame_cnt_inc;
    logic             pending_reg;
    logic             frame_vis_reg;
    logic             active_reg;
    logic             origin_reg;
    logic             at_origin;
    logic             frame_tick;
    logic             blank_d;
    logic [11:0]      bg_rgb;
    logic [11:0]      ovl_rgb;
    logic [11:0]      rgb_reg;

    // One tick per frame, even if the timing stage lingers on the origin.
    assign at_origin     = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign frame_tick    = at_origin && !origin_reg;
    assign frame_cnt_inc = frame_cnt_reg + CNT_W'(1);

    assign bg_rgb  = {bg_red, bg_green, bg_blue};
    assign ovl_rgb = {ovl_red, ovl_green, ovl_blue};

    pipe_delay #(
        .WIDTH (1),
        .DEPTH (PIPE_LAT)
    ) u_blank_delay (
        .clk  (vga_clk),
        .srst (Reset),
        .din  (blank),
        .dout (blank_d)
    );

    // Sequencer; frame_vis is computed from the post-transition state so it
    // is fixed for the whole upcoming frame.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= '0;
            pending_reg   <= 1'b0;
            frame_vis_reg <= 1'b0;
            active_reg    <= 1'b0;
            origin_reg    <= 1'b0;
        end else begin
            origin_reg <= at_origin;
            if (frame_tick) begin
                pending_reg <= 1'b0;
                if (pending_reg || hit_trigger) begin
                    state_reg     <= ST_SHOW;
                    frame_cnt_reg <= '0;
                    frame_vis_reg <= 1'b1;
                    active_reg    <= 1'b1;
                end else begin
                    case (state_reg)
                        ST_SHOW: begin
                            frame_vis_reg <= 1'b1;
                            if (frame_cnt_reg == SHOW_LAST) begin
                                state_reg     <= ST_BLINK;
                                frame_cnt_reg <= '0;
                            end else begin
                                frame_cnt_reg <= frame_cnt_inc;
                            end
                        end
                        ST_BLINK: begin
                            if (frame_cnt_reg == BLINK_LAST) begin
                                state_reg     <= ST_IDLE;
                                frame_cnt_reg <= '0;
                                frame_vis_reg <= 1'b0;
                                active_reg    <= 1'b0;
                            end else begin
                                frame_cnt_reg <= frame_cnt_inc;
                                frame_vis_reg <= !frame_cnt_inc[BLINK_SHIFT];
                            end
                        end
                        default: begin
                            state_reg     <= ST_IDLE;
                            frame_cnt_reg <= '0;
                            frame_vis_reg <= 1'b0;
                            active_reg    <= 1'b0;
                        end
                    endcase
                end
            end else if (hit_trigger) begin
                pending_reg <= 1'b1;
            end
        end
    end

    // Output mux: blanking wins, then a non-key sprite pixel, then the scene.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rgb_reg <= '0;
        end else if (!blank_d) begin
            rgb_reg <= '0;
        end else if (frame_vis_reg && (ovl_rgb != KEY_COLOR)) begin
            rgb_reg <= ovl_rgb;
        end else begin
            rgb_reg <= bg_rgb;
        end
    end

    assign red            = rgb_reg[11:8];
    assign green          = rgb_reg[7:4];
    assign blue           = rgb_reg[3:0];
    assign overlay_active = active_reg;

endmodule

// File: tb/tb_crithitz_overlay.sv
// Bench for crithitz_overlay: a frame-level model checked every cycle plus
// directed literal checks, on a shrunken raster so the full sequence stays short.
module tb_crithitz_overlay;

    localparam int          SHOW_FRAMES  = 60;
    localparam int          BLINK_FRAMES = 32;
    localparam int          BLINK_SHIFT  = 2;
    localparam int          PIPE_LAT     = 2;
    localparam logic [11:0] KEY          = 12'h000;
    localparam int          H_TOTAL      = 10;
    localparam int          V_TOTAL      = 3;
    localparam int          H_VIS        = 8;
    localparam int          V_VIS        = 2;

    logic       vga_clk     = 1'b0;
    logic       Reset       = 1'b1;
    logic       hit_trigger = 1'b0;
    logic       blank       = 1'b0;
    logic [9:0] DrawX       = 10'd5;
    logic [9:0] DrawY       = 10'd2;
    logic [11:0] bg_col     = 12'h123;
    logic [11:0] ovl_col    = 12'hF00;
    logic [3:0] bg_red, bg_green, bg_blue;
    logic [3:0] ovl_red, ovl_green, ovl_blue;
    logic [3:0] red, green, blue;
    logic       overlay_active;

    assign {bg_red, bg_green, bg_blue}    = bg_col;
    assign {ovl_red, ovl_green, ovl_blue} = ovl_col;

    always #5 vga_clk = ~vga_clk;

    crithitz_overlay #(
        .SHOW_FRAMES  (SHOW_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_SHIFT  (BLINK_SHIFT),
        .KEY_COLOR    (KEY),
        .PIPE_LAT     (PIPE_LAT)
    ) dut (
        .vga_clk        (vga_clk),
        .Reset          (Reset),
        .hit_trigger    (hit_trigger),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .blank          (blank),
        .bg_red         (bg_red),
        .bg_green       (bg_green),
        .bg_blue        (bg_blue),
        .ovl_red        (ovl_red),
        .ovl_green      (ovl_green),
        .ovl_blue       (ovl_blue),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .overlay_active (overlay_active)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int rx     = 0;
    int ry     = 0;
    bit chk_en = 1'b0;

    // Model: k counts frames since the display started; visibility follows
    // directly from k, and the pixel path from a blank history queue.
    logic [11:0] m_rgb    = 12'h000;
    bit          m_active = 1'b0;
    bit          m_on     = 1'b0;
    bit          m_pend   = 1'b0;
    bit          m_vis    = 1'b0;
    int          m_k      = 0;
    bit          blank_q[$];

    initial forever begin
        bit bd;
        @(posedge vga_clk);
        if (Reset) begin
            m_on = 0; m_pend = 0; m_vis = 0; m_k = 0;
            m_rgb = 12'h000; m_active = 0;
            blank_q.delete();
            repeat (PIPE_LAT) blank_q.push_back(1'b0);
        end else begin
            bd = blank_q.pop_front();
            blank_q.push_back(blank);
            if (!bd)
                m_rgb = 12'h000;
            else if (m_vis && ovl_col != KEY)
                m_rgb = ovl_col;
            else
                m_rgb = bg_col;
            if (DrawX == 10'd0 && DrawY == 10'd0) begin
                if (m_pend || hit_trigger) begin
                    m_on = 1; m_k = 0;
                end else if (m_on) begin
                    m_k = m_k + 1;
                    if (m_k >= SHOW_FRAMES + BLINK_FRAMES) m_on = 0;
                end
                m_pend = 0;
                m_vis  = m_on && (m_k < SHOW_FRAMES ||
                                  (((m_k - SHOW_FRAMES) >> BLINK_SHIFT) % 2) == 0);
            end else if (hit_trigger) begin
                m_pend = 1;
            end
            m_active = m_on;
        end
    end

    initial forever begin
        @(negedge vga_clk);
        if (chk_en) begin
            n_cmp++;
            if ({red, green, blue} !== m_rgb) begin
                n_fail++;
                $display("FAIL pixel t=%0t got %h expected %h", $time, {red, green, blue}, m_rgb);
            end
            n_cmp++;
            if (overlay_active !== m_active) begin
                n_fail++;
                $display("FAIL active t=%0t got %b expected %b", $time, overlay_active, m_active);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("check %s: got %h", name, got);
        end
    endtask

    task automatic drive(input logic trig, input logic rst);
        @(posedge vga_clk);
        #1;
        DrawX       = 10'(rx);
        DrawY       = 10'(ry);
        blank       = (rx < H_VIS) && (ry < V_VIS);
        hit_trigger = trig;
        Reset       = rst;
        if (rx == H_TOTAL - 1) begin
            rx = 0;
            ry = (ry == V_TOTAL - 1) ? 0 : ry + 1;
        end else begin
            rx = rx + 1;
        end
    endtask

    task automatic step();
        drive(1'b0, 1'b0);
    endtask

    // Advance the raster and drive the frame origin (with optional trigger).
    task automatic goto_origin(input logic trig);
        int guard = 0;
        while (!(rx == 0 && ry == 0) && guard < 2 * H_TOTAL * V_TOTAL) begin
            step();
            guard++;
        end
        if (!(rx == 0 && ry == 0)) begin
            n_cmp++; n_fail++;
            $display("FAIL goto_origin: raster bound expired");
        end
        drive(trig, 1'b0);
    endtask

    // Check the composited output for pixel (3,0) of the current frame.
    task automatic probe(input string name, input logic [11:0] exp);
        int guard = 0;
        while (!(rx == 3 && ry == 0) && guard < 2 * H_TOTAL * V_TOTAL) begin
            step();
            guard++;
        end
        step();
        repeat (PIPE_LAT + 1) step();
        @(negedge vga_clk);
        check(name, {red, green, blue}, exp);
    endtask

    task automatic expect_active(input string name, input logic exp);
        step();
        @(negedge vga_clk);
        check(name, {11'd0, overlay_active}, {11'd0, exp});
    endtask

    initial begin
        repeat (3) drive(1'b0, 1'b1);
        chk_en = 1'b1;
        @(negedge vga_clk);
        check("reset_rgb", {red, green, blue}, 12'h000);
        check("reset_active", {11'd0, overlay_active}, 12'h000);

        goto_origin(1'b0);
        probe("idle_bg", 12'h123);

        // Mid-frame trigger, full show + blink sequence.
        drive(1'b1, 1'b0);
        @(negedge vga_clk);
        check("pending_not_active", {11'd0, overlay_active}, 12'h000);
        goto_origin(1'b0);
        expect_active("show_entered", 1'b1);
        probe("show_f0", 12'hF00);
        for (int f = 1; f < SHOW_FRAMES + BLINK_FRAMES; f++) begin
            goto_origin(1'b0);
            if (f == 10) begin
                ovl_col = 12'h000;
                bg_col  = 12'h0A5;
                probe("key_transparent", 12'h0A5);
            end
            if (f == 11) begin
                ovl_col = 12'hF00;
                bg_col  = 12'h123;
            end
            case (f)
                59: probe("show_f59", 12'hF00);
                60: probe("blink_f0", 12'hF00);
                63: probe("blink_f3", 12'hF00);
                64: probe("blink_f4_hidden", 12'h123);
                67: probe("blink_f7_hidden", 12'h123);
                68: probe("blink_f8", 12'hF00);
                72: probe("blink_f12_hidden", 12'h123);
                91: probe("blink_f31_hidden", 12'h123);
                default: ;
            endcase
        end
        goto_origin(1'b0);
        expect_active("idle_after_92", 1'b0);
        probe("idle_bg_after", 12'h123);

        // Retrigger during blink frame 10.
        drive(1'b1, 1'b0);
        goto_origin(1'b0);
        for (int f = 1; f <= SHOW_FRAMES + 10; f++) goto_origin(1'b0);
        probe("blink_f10", 12'hF00);
        drive(1'b1, 1'b0);
        goto_origin(1'b0);
        expect_active("retrig_active", 1'b1);
        probe("retrig_f0", 12'hF00);
        for (int f = 1; f < SHOW_FRAMES + BLINK_FRAMES; f++) begin
            goto_origin(1'b0);
            if (f == 4) probe("retrig_f4", 12'hF00);
            if (f == 64) probe("retrig_blink_f4", 12'h123);
        end
        goto_origin(1'b0);
        expect_active("retrig_idle", 1'b0);

        // Trigger coincident with the frame tick.
        goto_origin(1'b1);
        expect_active("coincident_active", 1'b1);
        probe("coincident_show", 12'hF00);

        // Reset together with a trigger at show frame 20.
        for (int f = 1; f <= 20; f++) goto_origin(1'b0);
        step();
        step();
        drive(1'b1, 1'b1);
        step();
        @(negedge vga_clk);
        check("reset_mid_rgb", {red, green, blue}, 12'h000);
        check("reset_mid_active", {11'd0, overlay_active}, 12'h000);
        goto_origin(1'b0);
        expect_active("no_show_after_reset", 1'b0);
        probe("bg_after_reset", 12'h123);

        // Blanking edge at DrawX=640 while the sprite is visible.
        drive(1'b1, 1'b0);
        goto_origin(1'b0);
        step();
        ovl_col = 12'hFFF;
        for (int x = 636; x <= 646; x++) begin
            @(posedge vga_clk);
            #1;
            DrawX = 10'(x);
            DrawY = 10'd5;
            blank = (x < 640);
            @(negedge vga_clk);
            if (x == 642) check("pix639_visible", {red, green, blue}, 12'hFFF);
            if (x == 643) check("pix640_blanked", {red, green, blue}, 12'h000);
        end
        ovl_col = 12'hF00;
        goto_origin(1'b0);
        probe("show_resumes", 12'hF00);
        goto_origin(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
